// File: rtl/vm2002_change_dispenser_if.sv
// vm2002_change_dispenser_if
//   Bundles the change dispenser's request, refill, coin-eject and status
//   signals.
//   - slave modport: the dispenser.
//   - master modport: whatever drives payout requests and acks coins.
//
//   Handshakes:
//   - Request: start is accepted only while ready=1, and balance is captured
//     on that same edge.
//   - Coin eject: once coin_valid rises, coin_out holds steady until the
//     first edge where coin_ack=1. coin_valid drops on that edge. coin_ack
//     is ignored while coin_valid is low.
//
//   dbg_state exposes the dispenser FSM encoding for observation.
interface vm2002_change_dispenser_if #(
    parameter int AMT_W = 8,
    parameter int CNT_W = 6
);
    logic             start;
    logic [AMT_W-1:0] balance;
    logic             refill;
    logic [CNT_W-1:0] refill_q;
    logic [CNT_W-1:0] refill_d;
    logic [CNT_W-1:0] refill_n;
    logic             coin_ack;
    logic             ready;
    logic             coin_valid;
    logic [1:0]       coin_out;
    logic             done;
    logic             err;
    logic [AMT_W-1:0] remaining;
    logic [AMT_W-1:0] dispensed;
    logic [CNT_W-1:0] q_cnt;
    logic [CNT_W-1:0] d_cnt;
    logic [CNT_W-1:0] n_cnt;
    logic [2:0]       dbg_state;

    modport slave (
        input  start, balance, refill, refill_q, refill_d, refill_n, coin_ack,
        output ready, coin_valid, coin_out, done, err, remaining, dispensed,
               q_cnt, d_cnt, n_cnt, dbg_state
    );

    modport master (
        output start, balance, refill, refill_q, refill_d, refill_n, coin_ack,
        input  ready, coin_valid, coin_out, done, err, remaining, dispensed,
               q_cnt, d_cnt, n_cnt, dbg_state
    );
endinterface

// File: rtl/vm2002_change_dispenser.sv
// vm2002_change_dispenser
//   Pays out the balance owed after a vend as individual coins, choosing
//   coins greedily in the order quarter, dime, nickel. It keeps a stock
//   count for each coin type and pulses err when the balance is not a
//   multiple of 5 or when the remaining stock cannot cover it.
//   Coin codes: 1 = nickel (5), 2 = dime (10), 3 = quarter (25).
//
//   Ports:
//   - clk: clock. All logic updates on the rising edge.
//   - hrst: synchronous, active-high hard reset.
//   - bus (slave modport):
//     - request: start, balance, ready
//     - refill: refill, refill_q, refill_d, refill_n
//     - coin eject: coin_valid, coin_out, coin_ack
//     - status: done, err, remaining, dispensed, q_cnt, d_cnt, n_cnt,
//       dbg_state
module vm2002_change_dispenser #(
    parameter int AMT_W  = 8,
    parameter int CNT_W  = 6,
    parameter int INIT_Q = 20,
    parameter int INIT_D = 20,
    parameter int INIT_N = 20
) (
    input  logic                        clk,
    input  logic                        hrst,
    vm2002_change_dispenser_if.slave    bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        ISSUE  = 3'd2,
        DONE   = 3'd3,
        ERR    = 3'd4
    } state_t;

    state_t           state, state_d;
    logic [1:0]       sel_code;
    logic             coin_valid;
    logic [1:0]       coin_out;
    logic [AMT_W-1:0] remaining, dispensed, coin_val;
    logic [CNT_W-1:0] q_cnt, d_cnt, n_cnt;

    // Value of the coin currently presented; used on the ack edge.
    always_comb begin
        coin_val = '0;
        case (coin_out)
            2'd3:    coin_val = AMT_W'(25);
            2'd2:    coin_val = AMT_W'(10);
            2'd1:    coin_val = AMT_W'(5);
            default: coin_val = '0;
        endcase
    end

    // Next state and coin choice.
    // Coin choice is strictly greedy: pick the largest coin that fits and is
    // in stock, with no look-ahead. Coins are tried before the rem==0 check;
    // when rem==0 no coin can fit, so the order does not matter there.
    always_comb begin
        state_d  = state;
        sel_code = 2'd0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if ((bus.balance % AMT_W'(5)) != '0) state_d = ERR;
                    else if (bus.balance == '0)          state_d = DONE;
                    else                                 state_d = SELECT;
                end
            end
            SELECT: begin
                if (remaining >= AMT_W'(25) && q_cnt != '0)      sel_code = 2'd3;
                else if (remaining >= AMT_W'(10) && d_cnt != '0) sel_code = 2'd2;
                else if (remaining >= AMT_W'(5) && n_cnt != '0)  sel_code = 2'd1;
                if (sel_code != 2'd0)       state_d = ISSUE;
                else if (remaining == '0)   state_d = DONE;
                else                        state_d = ERR;
            end
            ISSUE:   if (bus.coin_ack) state_d = SELECT;
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (hrst) begin
            state      <= IDLE;
            coin_valid <= 1'b0;
            coin_out   <= 2'd0;
            remaining  <= '0;
            dispensed  <= '0;
            q_cnt      <= CNT_W'(INIT_Q);
            d_cnt      <= CNT_W'(INIT_D);
            n_cnt      <= CNT_W'(INIT_N);
        end else begin
            state <= state_d;
            case (state)
                IDLE: begin
                    // Refill lands on the same edge as start, so the first
                    // SELECT cycle already sees the new counts.
                    if (bus.refill) begin
                        q_cnt <= bus.refill_q;
                        d_cnt <= bus.refill_d;
                        n_cnt <= bus.refill_n;
                    end
                    if (bus.start) begin
                        remaining <= bus.balance;
                        dispensed <= '0;
                    end
                end
                SELECT: begin
                    if (sel_code != 2'd0) begin
                        coin_valid <= 1'b1;
                        coin_out   <= sel_code;
                    end
                end
                ISSUE: begin
                    if (bus.coin_ack) begin
                        remaining  <= remaining - coin_val;
                        dispensed  <= dispensed + coin_val;
                        coin_valid <= 1'b0;
                        coin_out   <= 2'd0;
                        // Guard the decrements so a count can never wrap.
                        case (coin_out)
                            2'd3: if (q_cnt != '0) q_cnt <= q_cnt - CNT_W'(1);
                            2'd2: if (d_cnt != '0) d_cnt <= d_cnt - CNT_W'(1);
                            2'd1: if (n_cnt != '0) n_cnt <= n_cnt - CNT_W'(1);
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ready      = (state == IDLE);
    assign bus.done       = (state == DONE);
    assign bus.err        = (state == ERR);
    assign bus.coin_valid = coin_valid;
    assign bus.coin_out   = coin_out;
    assign bus.remaining  = remaining;
    assign bus.dispensed  = dispensed;
    assign bus.q_cnt      = q_cnt;
    assign bus.d_cnt      = d_cnt;
    assign bus.n_cnt      = n_cnt;
    assign bus.dbg_state  = state;
endmodule

// File: tb/tb_vm2002_change_dispenser.sv
// tb_vm2002_change_dispenser
//   Directed bench for the change dispenser. Each test pushes the coins and
//   the final done/err event it expects into exp_q. A negedge monitor pops
//   and compares on every accepted coin and every done/err pulse. Balance,
//   stock and latency are checked directly after each payout.
module tb_vm2002_change_dispenser;
    localparam logic [3:0] EV_DONE = 4'b0100;
    localparam logic [3:0] EV_ERR  = 4'b1000;

    logic clk = 1'b0;
    logic hrst;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [3:0] exp_q[$];

    vm2002_change_dispenser_if bus ();

    vm2002_change_dispenser dut (
        .clk  (clk),
        .hrst (hrst),
        .bus  (bus)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_status(input string tag, input int rem, input int disp,
                                input int q, input int d, input int n);
        check({tag, "_ready"},     32'(bus.ready), 32'd1);
        check({tag, "_remaining"}, 32'(bus.remaining), 32'(rem));
        check({tag, "_dispensed"}, 32'(bus.dispensed), 32'(disp));
        check({tag, "_q_cnt"},     32'(bus.q_cnt), 32'(q));
        check({tag, "_d_cnt"},     32'(bus.d_cnt), 32'(d));
        check({tag, "_n_cnt"},     32'(bus.n_cnt), 32'(n));
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [3:0] got;
        logic [3:0] want;
        if (!hrst && ((bus.coin_valid && bus.coin_ack) || bus.done || bus.err)) begin
            got = bus.done ? EV_DONE : bus.err ? EV_ERR : {2'b00, bus.coin_out};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got event %0h expected none", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL sb_event: got %0h expected %0h", got, want);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        hrst = 1'b1;
        @(posedge clk); #1;
        hrst = 1'b0;
    endtask

    task automatic do_refill(input int q, input int d, input int n);
        bus.refill   = 1'b1;
        bus.refill_q = 6'(q);
        bus.refill_d = 6'(d);
        bus.refill_n = 6'(n);
        @(posedge clk); #1;
        bus.refill = 1'b0;
    endtask

    // Issues start (optionally with a simultaneous refill) and acks every
    // presented coin after holding it for 'hold' cycles. Returns once the
    // dispenser is back in IDLE.
    task automatic pay(input string tag, input int bal, input int hold, input int exp_lat,
                       input bit with_refill, input int rq, input int rd, input int rn);
        int lat;
        bit fin;
        bit first;
        logic [1:0] held;
        bus.balance = 8'(bal);
        bus.start   = 1'b1;
        if (with_refill) begin
            bus.refill   = 1'b1;
            bus.refill_q = 6'(rq);
            bus.refill_d = 6'(rd);
            bus.refill_n = 6'(rn);
        end
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus.refill = 1'b0;
        lat = 1; fin = 1'b0; first = 1'b1;
        for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
            if (bus.coin_valid) begin
                if (first) begin
                    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
                    first = 1'b0;
                end
                held = bus.coin_out;
                for (int h = 0; h < hold; h++) begin
                    @(posedge clk); #1;
                    check({tag, "_hold_valid"}, 32'(bus.coin_valid), 32'd1);
                    check({tag, "_hold_code"}, 32'(bus.coin_out), 32'(held));
                end
                bus.coin_ack = 1'b1;
                @(posedge clk); #1;
                bus.coin_ack = 1'b0;
            end else if (bus.done || bus.err) begin
                if (first) check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
                fin = 1'b1;
            end else begin
                @(posedge clk); #1;
                lat++;
            end
        end
        if (!fin) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got no done/err expected one within 300 cycles", tag);
        end
        @(posedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        hrst         = 1'b1;
        bus.start    = 1'b0;
        bus.balance  = '0;
        bus.refill   = 1'b0;
        bus.refill_q = '0;
        bus.refill_d = '0;
        bus.refill_n = '0;
        bus.coin_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        check("rst_coin_valid", 32'(bus.coin_valid), 32'd0);
        check("rst_coin_out",   32'(bus.coin_out), 32'd0);
        check("rst_done",       32'(bus.done), 32'd0);
        check("rst_err",        32'(bus.err), 32'd0);
        check_status("rst", 0, 0, 20, 20, 20);

        // 65 = 25 + 25 + 10 + 5
        exp_q.push_back(4'd3); exp_q.push_back(4'd3);
        exp_q.push_back(4'd2); exp_q.push_back(4'd1);
        exp_q.push_back(EV_DONE);
        pay("t65", 65, 0, 2, 1'b0, 0, 0, 0);
        check_status("t65", 0, 65, 18, 19, 19);

        // Not a multiple of 5: err with no coins, full balance left owing.
        exp_q.push_back(EV_ERR);
        pay("t33", 33, 0, 1, 1'b0, 0, 0, 0);
        check_status("t33", 33, 0, 18, 19, 19);

        // Stock short: one quarter, then no nickel for the last 5.
        do_refill(1, 0, 0);
        check_status("refill1", 33, 0, 1, 0, 0);
        exp_q.push_back(4'd3); exp_q.push_back(EV_ERR);
        pay("t30", 30, 0, 2, 1'b0, 0, 0, 0);
        check_status("t30", 5, 25, 0, 0, 0);

        // No quarters, slow ack: four dimes, each held 5 cycles.
        do_refill(0, 20, 20);
        repeat (4) exp_q.push_back(4'd2);
        exp_q.push_back(EV_DONE);
        pay("t40", 40, 5, 2, 1'b0, 0, 0, 0);
        check_status("t40", 0, 40, 0, 16, 20);

        // Greedy takes the quarter first and cannot backtrack to 3 dimes.
        do_refill(1, 3, 0);
        exp_q.push_back(4'd3); exp_q.push_back(EV_ERR);
        pay("tgreedy", 30, 0, 2, 1'b0, 0, 0, 0);
        check_status("tgreedy", 5, 25, 0, 3, 0);

        // Refill together with start: SELECT sees the refilled counts.
        exp_q.push_back(4'd3); exp_q.push_back(4'd3);
        exp_q.push_back(4'd1); exp_q.push_back(EV_DONE);
        pay("trefstart", 55, 0, 2, 1'b1, 2, 0, 1);
        check_status("trefstart", 0, 55, 0, 0, 0);

        // Zero balance: done immediately, no coins.
        exp_q.push_back(EV_DONE);
        pay("tzero", 0, 0, 1, 1'b0, 0, 0, 0);
        check_status("tzero", 0, 0, 0, 0, 0);

        // Hard reset while a coin is presented but not acked.
        do_refill(5, 5, 5);
        bus.balance = 8'd65;
        bus.start   = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int cyc = 0; cyc < 20 && !bus.coin_valid; cyc++) begin
            @(posedge clk); #1;
        end
        check("thrst_presented", 32'(bus.coin_valid), 32'd1);
        hrst = 1'b1;
        @(posedge clk); #1;
        hrst = 1'b0;
        check("thrst_coin_valid", 32'(bus.coin_valid), 32'd0);
        check("thrst_coin_out",   32'(bus.coin_out), 32'd0);
        check_status("thrst", 0, 0, 20, 20, 20);

        repeat (3) @(posedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
